// File: rtl/seq_divider_if.sv
// seq_divider_if: request/response bundle for the sequential divider.
// master drives the operation request; slave (the divider) returns status and result.
interface seq_divider_if #(
  parameter int unsigned WIDTH = 32
);
  logic               start;
  logic               signed_op;
  logic [WIDTH-1:0]   dividend;
  logic [WIDTH-1:0]   divisor;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] result;
  logic               div_by_zero;

  modport master (
    output start, signed_op, dividend, divisor,
    input  busy, done, result, div_by_zero
  );

  modport slave (
    input  start, signed_op, dividend, divisor,
    output busy, done, result, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider, one quotient bit per clock.
// result = {remainder, quotient}; signed or unsigned mode chosen per operation.
// Optional macro DIV_ZERO_DETECT_EN: a zero divisor short-circuits to a one-cycle
// operation with div_by_zero=1 and result {dividend, all-ones}.
module seq_divider #(
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input logic         clock,
  input logic         reset,
  seq_divider_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StDiv, StFix} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   div_q, div_d;     // |B|
  logic [WIDTH:0]     rem_q, rem_d;     // upper partial field, WIDTH+1 bits
  logic [WIDTH-1:0]   quo_q, quo_d;     // lower partial field, becomes quotient
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               dbz_q, dbz_d;
  logic               done_q, done_d;
`ifdef DIV_ZERO_DETECT_EN
  logic               zero_q, zero_d;
`endif

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH+1:0]   shifted, trial;

  // Operand magnitudes and one restoring step on the shared subtractor.
  always_comb begin
    a_neg   = bus.signed_op & bus.dividend[WIDTH-1];
    b_neg   = bus.signed_op & bus.divisor[WIDTH-1];
    a_mag   = a_neg ? -bus.dividend : bus.dividend;
    b_mag   = b_neg ? -bus.divisor : bus.divisor;
    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = shifted - {2'b00, div_q};
  end

  // Next-state and datapath update for the IDLE/DIV/FIX sequence.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    div_d     = div_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    result_d  = result_q;
    dbz_d     = dbz_q;
    done_d    = 1'b0;
`ifdef DIV_ZERO_DETECT_EN
    zero_d    = zero_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          neg_quo_d = bus.signed_op & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
          neg_rem_d = a_neg;
          div_d     = b_mag;
          rem_d     = '0;
          quo_d     = a_mag;
          count_d   = '0;
          state_d   = StDiv;
`ifdef DIV_ZERO_DETECT_EN
          zero_d    = 1'b0;
          if (bus.divisor == '0) begin
            // Keep the raw dividend for the {dividend, all-ones} result.
            zero_d  = 1'b1;
            quo_d   = bus.dividend;
            state_d = StFix;
          end
`endif
        end
      end
      StDiv: begin
        // Negative trial (top bit set) means restore the shifted value.
        rem_d   = trial[WIDTH+1] ? shifted[WIDTH:0] : trial[WIDTH:0];
        quo_d   = {quo_q[WIDTH-2:0], ~trial[WIDTH+1]};
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_W'(WIDTH - 1)) state_d = StFix;
      end
      StFix: begin
        done_d   = 1'b1;
        state_d  = StIdle;
        result_d = {neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0],
                    neg_quo_q ? -quo_q : quo_q};
`ifdef DIV_ZERO_DETECT_EN
        dbz_d    = zero_q;
        if (zero_q) result_d = {quo_q, {WIDTH{1'b1}}};
`else
        dbz_d    = 1'b0;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      count_q   <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      result_q  <= '0;
      dbz_q     <= 1'b0;
      done_q    <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
      zero_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      div_q     <= div_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      result_q  <= result_d;
      dbz_q     <= dbz_d;
      done_q    <= done_d;
`ifdef DIV_ZERO_DETECT_EN
      zero_q    <= zero_d;
`endif
    end
  end

  assign bus.busy        = (state_q != StIdle);
  assign bus.done        = done_q;
  assign bus.result      = result_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: scoreboard bench for seq_divider (WIDTH=32). The driver pushes the
// reference result and expected done edge; the monitor checks every done pulse.
module tb_seq_divider;
  localparam int W = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;

  seq_divider_if #(.WIDTH(W)) bus ();

  seq_divider #(.WIDTH(W)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  // Number of rising edges so far; at a negedge it is the index of the last edge.
  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [2*W-1:0] res;
    logic           dz;
    int unsigned    at;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer division rules, with the zero-divisor conventions.
  function automatic exp_t model(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input int unsigned start_edge);
    exp_t        m;
    logic [W-1:0] q, r;
    longint      x, y, qq, rr;
    m.dz = 1'b0;
    m.at = start_edge + W + 1;
    if (b == '0) begin
`ifdef DIV_ZERO_DETECT_EN
      q    = '1;
      r    = a;
      m.dz = 1'b1;
      m.at = start_edge + 1;
`else
      // Magnitude quotient all ones, remainder |A|; then sign fixes.
      if (sgn && a[W-1]) begin
        q = 32'd1;
        r = a;
      end else begin
        q = '1;
        r = a;
      end
`endif
    end else begin
      if (sgn) begin
        x = longint'($signed(a));
        y = longint'($signed(b));
      end else begin
        x = longint'({32'h0, a});
        y = longint'({32'h0, b});
      end
      qq = x / y;
      rr = x % y;
      q  = qq[W-1:0];
      r  = rr[W-1:0];
    end
    m.res = {r, q};
    return m;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (!reset && bus.done) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spurious_done: got done=1 expected no done (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        check("result", bus.result, e.res);
        check("div_by_zero", {63'd0, bus.div_by_zero}, {63'd0, e.dz});
        check("done_edge", {32'd0, cyc}, {32'd0, e.at});
        check("busy_at_done", {63'd0, bus.busy}, 64'd0);
      end
    end
  end

  // Issue one operation at a negedge once the divider is idle.
  task automatic issue(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    int guard = 0;
    while (bus.busy && guard < 100) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 100) begin
      tests++;
      fails++;
      $display("FAIL busy_timeout: got busy=1 expected busy=0 within 100 cycles");
    end
    bus.start     = 1'b1;
    bus.signed_op = sgn;
    bus.dividend  = a;
    bus.divisor   = b;
    sb.push_back(model(sgn, a, b, cyc + 1));
    @(negedge clock);
    bus.start = 1'b0;
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(0, 6))
      0:       v = '0;
      1:       v = 32'h8000_0000;
      2:       v = '1;
      3:       v = 32'($urandom_range(0, 15));
      4:       v = -32'($urandom_range(1, 15));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    bus.start     = 1'b0;
    bus.signed_op = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    repeat (3) @(negedge clock);
    check("reset_busy", {63'd0, bus.busy}, 64'd0);
    check("reset_done", {63'd0, bus.done}, 64'd0);
    check("reset_result", bus.result, 64'd0);
    check("reset_dbz", {63'd0, bus.div_by_zero}, 64'd0);
    reset = 1'b0;
    @(negedge clock);

    issue(1'b1, 32'd100, 32'd7);
    check("busy_after_start", {63'd0, bus.busy}, 64'd1);
    issue(1'b1, -32'd100, 32'd7);
    issue(1'b1, 32'd100, -32'd7);
    issue(1'b1, -32'd100, -32'd7);
    issue(1'b0, 32'hFFFF_FFFF, 32'h8000_0000);
    issue(1'b1, 32'hFFFF_FFFF, 32'h8000_0000);

    // Overflow case, with a stray start mid-operation that must be ignored.
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    repeat (9) @(negedge clock);
    bus.start    = 1'b1;
    bus.dividend = 32'd1234;
    bus.divisor  = 32'd3;
    @(negedge clock);
    bus.start = 1'b0;

    // Back-to-back: issued in the done cycle of the previous operation.
    issue(1'b0, 32'd50, 32'd5);
    issue(1'b1, 32'd9, 32'd0);
    issue(1'b0, 32'd9, 32'd0);
    issue(1'b1, -32'd7, 32'd0);
    issue(1'b1, 32'd7, 32'd0);

    // Reset mid-operation aborts with no done pulse.
    issue(1'b0, 32'd1000, 32'd3);
    repeat (14) @(negedge clock);
    reset = 1'b1;
    sb.delete();
    @(negedge clock);
    check("abort_busy", {63'd0, bus.busy}, 64'd0);
    check("abort_done", {63'd0, bus.done}, 64'd0);
    check("abort_result", bus.result, 64'd0);
    check("abort_dbz", {63'd0, bus.div_by_zero}, 64'd0);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    check("abort_idle_result", bus.result, 64'd0);

    for (int i = 0; i < 150; i++) begin
      issue(1'($urandom_range(0, 1)), pick(), pick());
      // Occasional idle gap between operations.
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 40)) @(negedge clock);
    end

    begin
      int guard = 0;
      while (sb.size() != 0 && guard < 200) begin
        @(negedge clock);
        guard++;
      end
      if (sb.size() != 0) begin
        tests++;
        fails++;
        $display("FAIL drain_timeout: got %0d pending results expected 0", sb.size());
      end
    end
    repeat (5) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
